// File: rtl/seg_pattern_rx.sv
// Receive side of the two-digit seven-segment pattern link: deserialises a 16-bit
// active-low pattern word, decodes it to a value 0..15 and holds it until accepted.
module seg_pattern_rx #(
    parameter int DP_CHECK  = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ser_in,
    input  logic                 ser_valid,
    input  logic                 ser_sync,
    output logic                 in_ready,
    output logic [3:0]           out_value,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [1:0] ST_SHIFT  = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [1:0]  state;
    logic [3:0]  bit_cnt;
    logic [15:0] shreg;

    logic [4:0]  tens_d;
    logic [4:0]  ones_d;
    logic        dp_bad;
    logic        dec_err;
    logic [3:0]  dec_value;

    // Returns {illegal, digit}; illegal codes come back as 5'h1F.
    function automatic logic [4:0] seg_digit(input logic [6:0] code);
        case (code)
            7'h40:   return 5'd0;
            7'h79:   return 5'd1;
            7'h24:   return 5'd2;
            7'h30:   return 5'd3;
            7'h19:   return 5'd4;
            7'h12:   return 5'd5;
            7'h02:   return 5'd6;
            7'h78:   return 5'd7;
            7'h00:   return 5'd8;
            7'h10:   return 5'd9;
            default: return 5'h1F;
        endcase
    endfunction

    always_comb begin
        tens_d    = seg_digit(shreg[14:8]);
        ones_d    = seg_digit(shreg[6:0]);
        dp_bad    = (DP_CHECK != 0) && !(shreg[15] && shreg[7]);
        dec_err   = tens_d[4] || ones_d[4] || dp_bad
                    || (tens_d[3:0] >= 4'd2)
                    || ((tens_d[3:0] == 4'd1) && (ones_d[3:0] > 4'd5));
        dec_value = 4'd0;
        if (!dec_err) begin
            dec_value = (tens_d[3:0] == 4'd0) ? ones_d[3:0] : 4'd10 + ones_d[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SHIFT;
            bit_cnt   <= 4'd0;
            shreg     <= 16'd0;
            out_value <= 4'd0;
            out_err   <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (ser_sync) begin
                        // A bit arriving with the resync strobe starts the new frame.
                        if (ser_valid) begin
                            shreg   <= {15'd0, ser_in};
                            bit_cnt <= 4'd1;
                        end else begin
                            shreg   <= 16'd0;
                            bit_cnt <= 4'd0;
                        end
                    end else if (ser_valid) begin
                        shreg   <= {shreg[14:0], ser_in};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            state <= ST_DECODE;
                        end
                    end
                end
                ST_DECODE: begin
                    out_value <= dec_value;
                    out_err   <= dec_err;
                    if (dec_err && (err_count != {ERR_CNT_W{1'b1}})) begin
                        err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
                    end
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= 4'd0;
                        shreg   <= 16'd0;
                    end
                end
                default: begin
                    state <= ST_SHIFT;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_SHIFT);
    assign out_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_seg_pattern_rx.sv
// Randomised self-checking bench for seg_pattern_rx against a digit-table reference model.
module tb_seg_pattern_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_in = 1'b0;
    logic       ser_valid = 1'b0;
    logic       ser_sync = 1'b0;
    logic       in_ready;
    logic [3:0] out_value;
    logic       out_err;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int err_exp  = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg_pattern_rx #(.DP_CHECK(1), .ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .ser_sync  (ser_sync),
        .in_ready  (in_ready),
        .out_value (out_value),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: look both digits up in the table, value = tens*10 + ones.
    function automatic void ref_decode(input logic [15:0] w, output logic [3:0] v, output logic e);
        int t;
        int o;
        int num;
        t = -1;
        o = -1;
        for (int i = 0; i < 10; i++) begin
            if (seg_tab[i] == w[14:8]) t = i;
            if (seg_tab[i] == w[6:0])  o = i;
        end
        num = t * 10 + o;
        e = (t < 0) || (o < 0) || (num > 15) || !w[15] || !w[7];
        v = e ? 4'd0 : 4'(num);
    endfunction

    function automatic logic [15:0] encode(input int val);
        return {1'b1, seg_tab[val / 10], 1'b1, seg_tab[val % 10]};
    endfunction

    task automatic send_bit(input logic b, input logic sync);
        while ($urandom_range(0, 3) == 0) begin
            ser_valid = 1'b0;
            @(posedge clk); #1;
            check("idle_in_ready", in_ready, 1);
        end
        ser_in    = b;
        ser_valid = 1'b1;
        ser_sync  = sync;
        @(posedge clk); #1;
        ser_valid = 1'b0;
        ser_sync  = 1'b0;
    endtask

    task automatic finish_frame(input logic [15:0] w, input int hold);
        logic [3:0] v;
        logic       e;
        check("decode_in_ready", in_ready, 0);
        check("decode_valid", out_valid, 0);
        ref_decode(w, v, e);
        if (e && err_exp < 255) err_exp++;
        @(posedge clk); #1;
        check("out_valid", out_valid, 1);
        check("out_value", out_value, v);
        check("out_err", out_err, e);
        check("err_count", err_count, err_exp);
        $display("frame %h -> value %0d err %0b err_count %0d", w, out_value, out_err, err_count);
        for (int k = 0; k < hold; k++) begin
            ser_valid = 1'b1;
            ser_in    = 1'($urandom);
            ser_sync  = 1'($urandom);
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_value", out_value, v);
            check("hold_err", out_err, e);
        end
        ser_valid = 1'b0;
        ser_sync  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    task automatic send_frame(input logic [15:0] w, input int hold);
        for (int i = 15; i >= 0; i--) begin
            send_bit(w[i], 1'b0);
            if (i != 0) check("shift_in_ready", in_ready, 1);
        end
        finish_frame(w, hold);
    endtask

    initial begin
        logic [15:0] w;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_value", out_value, 0);
        check("rst_out_err", out_err, 0);
        check("rst_err_count", err_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        send_frame(16'hC0F9, 0);
        send_frame(16'hF9B0, 0);
        send_frame(16'hC0C0, 0);
        send_frame(16'hF982, 0);
        send_frame(16'hC0FF, 0);
        send_frame(16'h40C0, 0);
        send_frame(16'hC0F9, 5);

        // Partial frame, resync with a bit, then the rest of the frame.
        w = 16'hF9A4;
        for (int i = 0; i < 7; i++) send_bit(1'($urandom), 1'b0);
        send_bit(w[15], 1'b1);
        for (int i = 14; i >= 0; i--) send_bit(w[i], 1'b0);
        finish_frame(w, 1);

        // Resync without a bit.
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
        ser_sync = 1'b1;
        @(posedge clk); #1;
        ser_sync = 1'b0;
        send_frame(16'hF9F9, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                w = encode($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) w[15] = 1'b0;
            end else begin
                w = 16'($urandom);
            end
            send_frame(w, $urandom_range(0, 3));
        end

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_err_count", err_count, 0);
        check("midrst_out_value", out_value, 0);
        err_exp = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_frame(16'hC099, 0);

        for (int n = 0; n < 260; n++) send_frame(16'hC0FF, 0);
        check("err_saturated", err_count, 8'hFF);
        send_frame(16'hC0F9, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
